// File: rtl/alu_pkg.sv
// Shared opcode encodings and default widths for the registered ALU.
package alu_pkg;

    localparam int unsigned DEF_SIZEDATA = 8;
    localparam int unsigned DEF_SIZEOP   = 6;

    // MIPS funct field codes
    localparam logic [DEF_SIZEOP-1:0] ADD = 6'b100000;
    localparam logic [DEF_SIZEOP-1:0] SUB = 6'b100010;
    localparam logic [DEF_SIZEOP-1:0] AND = 6'b100100;
    localparam logic [DEF_SIZEOP-1:0] OR  = 6'b100101;
    localparam logic [DEF_SIZEOP-1:0] XOR = 6'b100110;
    localparam logic [DEF_SIZEOP-1:0] NOR = 6'b100111;
    localparam logic [DEF_SIZEOP-1:0] SRA = 6'b000011;
    localparam logic [DEF_SIZEOP-1:0] SRL = 6'b000010;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: eight funct-coded operations, unknown codes give zero.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned SIZEDATA = DEF_SIZEDATA,
    parameter int unsigned SIZEOP   = DEF_SIZEOP
) (
    input  logic [SIZEDATA-1:0] DATOA,
    input  logic [SIZEDATA-1:0] DATOB,
    input  logic [SIZEOP-1:0]   OPCODE,
    output logic [SIZEDATA-1:0] RESULT,
    output logic                CARRY
);

    logic [SIZEDATA:0]   sum;
    logic                big_shift;
    logic [SIZEDATA-1:0] sign_fill;

    assign sum       = {1'b0, DATOA} + {1'b0, DATOB};
    // Shift amounts of W or more saturate to full sign/zero fill
    assign big_shift = (DATOB >= SIZEDATA[SIZEDATA-1:0]) || (SIZEDATA >= 32'(1 << SIZEDATA));
    assign sign_fill = {SIZEDATA{DATOA[SIZEDATA-1]}};

    always_comb begin
        RESULT = '0;
        CARRY  = 1'b0;
        case (OPCODE)
            ADD: {CARRY, RESULT} = sum;
            SUB: begin
                RESULT = DATOA - DATOB;
                CARRY  = (DATOA < DATOB);
            end
            AND: RESULT = DATOA & DATOB;
            OR:  RESULT = DATOA | DATOB;
            XOR: RESULT = DATOA ^ DATOB;
            NOR: RESULT = ~(DATOA | DATOB);
            SRA: RESULT = big_shift ? sign_fill : SIZEDATA'($signed(DATOA) >>> DATOB);
            SRL: RESULT = big_shift ? '0 : (DATOA >> DATOB);
            default: begin
                RESULT = '0;
                CARRY  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_reg.sv
// ALU with one-cycle registered RESULT/CARRY and synchronous active-high reset.
module alu_reg
    import alu_pkg::*;
#(
    parameter int unsigned SIZEDATA = DEF_SIZEDATA,
    parameter int unsigned SIZEOP   = DEF_SIZEOP
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [SIZEDATA-1:0] DATOA,
    input  logic [SIZEDATA-1:0] DATOB,
    input  logic [SIZEOP-1:0]   OPCODE,
    output logic [SIZEDATA-1:0] RESULT,
    output logic                CARRY
);

    logic [SIZEDATA-1:0] core_result;
    logic                core_carry;

    alu_core #(
        .SIZEDATA(SIZEDATA),
        .SIZEOP  (SIZEOP)
    ) u_core (
        .DATOA (DATOA),
        .DATOB (DATOB),
        .OPCODE(OPCODE),
        .RESULT(core_result),
        .CARRY (core_carry)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            RESULT <= '0;
            CARRY  <= 1'b0;
        end else begin
            RESULT <= core_result;
            CARRY  <= core_carry;
        end
    end

endmodule

// File: tb/tb_alu_reg.sv
// Randomised and directed checks of alu_reg against an integer-arithmetic reference model.
module tb_alu_reg;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] DATOA, DATOB;
    logic [5:0] OPCODE;
    logic [7:0] RESULT;
    logic       CARRY;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    logic [8:0]  prev_exp;

    localparam logic [5:0] C_ADD = 6'b100000, C_SUB = 6'b100010, C_AND = 6'b100100,
                           C_OR  = 6'b100101, C_XOR = 6'b100110, C_NOR = 6'b100111,
                           C_SRA = 6'b000011, C_SRL = 6'b000010, C_BAD = 6'b111111;

    always #5 CLK = ~CLK;

    alu_reg #(.SIZEDATA(8), .SIZEOP(6)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .DATOA (DATOA),
        .DATOB (DATOB),
        .OPCODE(OPCODE),
        .RESULT(RESULT),
        .CARRY (CARRY)
    );

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got carry=%0b result=0x%02h, expected carry=%0b result=0x%02h",
                     tag, got[8], got[7:0], exp[8], exp[7:0]);
        end
    endtask

    // Returns {carry, result} computed with plain integer arithmetic.
    function automatic logic [8:0] model(input logic [5:0] op, input int a, input int b);
        int r, c, sa;
        r = 0; c = 0;
        case (op)
            C_ADD: begin r = (a + b) % 256; c = (a + b) / 256; end
            C_SUB: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
            C_AND: r = a & b;
            C_OR:  r = a | b;
            C_XOR: r = a ^ b;
            C_NOR: r = 255 - (a | b);
            C_SRA: begin
                sa = (a >= 128) ? a - 256 : a;
                r  = (sa >>> ((b > 31) ? 31 : b)) & 255;
            end
            C_SRL: r = (b >= 8) ? 0 : (a >> b);
            default: begin r = 0; c = 0; end
        endcase
        return {c[0], r[7:0]};
    endfunction

    // Drive at negedge; outputs must not move before the edge and must show the new result after it.
    task automatic apply(input string tag, input logic rst, input logic [5:0] op,
                         input logic [7:0] a, input logic [7:0] b);
        logic [8:0] exp;
        @(negedge CLK);
        RESET = rst; OPCODE = op; DATOA = a; DATOB = b;
        #1 check({tag, "/hold"}, {CARRY, RESULT}, prev_exp);
        exp = rst ? 9'h000 : model(op, int'(a), int'(b));
        @(posedge CLK);
        #1 check(tag, {CARRY, RESULT}, exp);
        prev_exp = exp;
    endtask

    logic [5:0] ops [9] = '{C_ADD, C_SUB, C_AND, C_OR, C_XOR, C_NOR, C_SRA, C_SRL, C_BAD};

    initial begin
        RESET = 1'b1; OPCODE = C_ADD; DATOA = 8'd200; DATOB = 8'd200;
        @(posedge CLK); @(posedge CLK);
        #1 check("reset", {CARRY, RESULT}, 9'h000);
        prev_exp = 9'h000;

        apply("add_ovf",  1'b0, C_ADD, 8'd200, 8'd200);
        check("add_ovf_const", {CARRY, RESULT}, 9'h190);
        apply("add_small", 1'b0, C_ADD, 8'd4, 8'd1);
        apply("sub_pos",  1'b0, C_SUB, 8'd8, 8'd2);
        apply("sub_brw",  1'b0, C_SUB, 8'd2, 8'd8);
        check("sub_brw_const", {CARRY, RESULT}, 9'h1FA);
        apply("and",      1'b0, C_AND, 8'd7, 8'd2);
        apply("or",       1'b0, C_OR,  8'd8, 8'd2);
        apply("xor",      1'b0, C_XOR, 8'd4, 8'd4);
        apply("nor",      1'b0, C_NOR, 8'd8, 8'd2);
        check("nor_const", {CARRY, RESULT}, 9'h0F5);
        apply("sra_pos",  1'b0, C_SRA, 8'h04, 8'd2);
        apply("sra_neg",  1'b0, C_SRA, 8'h80, 8'd2);
        check("sra_neg_const", {CARRY, RESULT}, 9'h0E0);
        apply("sra_big",  1'b0, C_SRA, 8'h80, 8'd9);
        check("sra_big_const", {CARRY, RESULT}, 9'h0FF);
        apply("srl",      1'b0, C_SRL, 8'h08, 8'd2);
        apply("srl_msb",  1'b0, C_SRL, 8'h80, 8'd2);
        apply("srl_big",  1'b0, C_SRL, 8'hFF, 8'd8);
        apply("srl_w-1",  1'b0, C_SRL, 8'hFF, 8'd7);
        apply("illegal",  1'b0, C_BAD, 8'h55, 8'hAA);

        // Back-to-back opcode changes every cycle
        for (int i = 0; i < 12; i++)
            apply("stream", 1'b0, ops[i % 3 == 0 ? 0 : (i % 3 == 1 ? 1 : 4)],
                  8'($urandom_range(255)), 8'($urandom_range(255)));
        apply("rst_mid",  1'b1, C_ADD, 8'd200, 8'd200);
        apply("after_rst", 1'b0, C_ADD, 8'd200, 8'd200);

        for (int i = 0; i < 300; i++)
            apply("rand", ($urandom_range(15) == 0), ops[$urandom_range(8)],
                  8'($urandom_range(255)),
                  ($urandom_range(3) == 0) ? 8'($urandom_range(12)) : 8'($urandom_range(255)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
